// File: rtl/hazard_flush_gen_pkg.sv
// Shared types for the flush/stall hazard generator.
// FSM state encoding and default widths.
package hazard_flush_gen_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int PC_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    STALL = 2'd2
  } state_t;

endpackage

// File: rtl/hazard_flush_gen_load_use_detect.sv
// Load-use hit compare between the load in EX and the instr in ID.
// Purely combinational.
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_readdmem,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  hit
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = id_uses_rs && (id_rs == ex_rd);
  assign rt_hit = id_uses_rt && (id_rt == ex_rd);

  // r0 is hardwired zero, so a load into it never creates a hazard
  assign hit = ex_readdmem && (ex_rd != '0)
            && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_flush_gen.sv
// Flush/stall producer: taken-branch redirect + flush hold,
// load-use stall, saturating event counters.
module hazard_flush_gen
  import hazard_flush_gen_pkg::*;
#(
  parameter int REG_ADDR_W   = 5,
  parameter int PC_W         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  ex_readdmem,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_branch_taken,
  input  logic [PC_W-1:0]       ex_target,
  output logic                  flush,
  output logic                  stall_pc,
  output logic                  stall_ifid,
  output logic                  pc_redirect,
  output logic [PC_W-1:0]       pc_target,
  output logic                  busy,
  output logic [CNT_W-1:0]      flush_events,
  output logic [CNT_W-1:0]      stall_events
);

  localparam int REM_W = $clog2(FLUSH_CYCLES) + 1;
  localparam logic [REM_W-1:0] REM_INIT =
    REM_W'(FLUSH_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [REM_W-1:0] rem_q;
  logic [REM_W-1:0] rem_d;
  logic [PC_W-1:0]  tgt_q;
  logic [CNT_W-1:0] fcnt_q;
  logic [CNT_W-1:0] scnt_q;

  logic hit;
  logic idle;
  logic take;
  logic lu_stall;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_lud (
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rs  (id_uses_rs),
    .id_uses_rt  (id_uses_rt),
    .ex_readdmem (ex_readdmem),
    .ex_rd       (ex_rd),
    .hit         (hit)
  );

  // Hazards are only sampled in IDLE; branch wins over load-use
  assign idle     = (state_q == IDLE);
  assign take     = idle && ex_branch_taken;
  assign lu_stall = idle && !ex_branch_taken && hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      tgt_q   <= '0;
      fcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      if (take) tgt_q <= ex_target;
      if (take && (fcnt_q != '1))
        fcnt_q <= fcnt_q + CNT_W'(1);
      if (lu_stall && (scnt_q != '1))
        scnt_q <= scnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
          rem_d = REM_INIT;
          if (FLUSH_CYCLES > 1) state_d = FLUSH;
        end else if (lu_stall) begin
          state_d = STALL;
        end
      end
      FLUSH: begin
        rem_d = rem_q - REM_W'(1);
        if (rem_q <= REM_W'(1)) state_d = IDLE;
      end
      STALL:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    flush       = 1'b0;
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    pc_redirect = 1'b0;
    busy        = 1'b0;
    pc_target   = tgt_q;
    if (rst) begin
      pc_target = '0;
    end else begin
      flush       = take || lu_stall
                 || (state_q == FLUSH);
      stall_pc    = lu_stall;
      stall_ifid  = lu_stall;
      pc_redirect = take;
      busy        = !idle;
      if (take) pc_target = ex_target;
    end
  end

  assign flush_events = fcnt_q;
  assign stall_events = scnt_q;

endmodule

// File: tb/tb_hazard_flush_gen.sv
// Scoreboard bench for hazard_flush_gen: two parameterisations
// driven in lockstep, checked against a cycle-level reference model.
module tb_hazard_flush_gen;

  typedef struct {
    bit         rst;
    logic [4:0] rs;
    logic [4:0] rt;
    bit         urs;
    bit         urt;
    bit         ld;
    logic [4:0] rd;
    bit         br;
    logic [31:0] tg;
  } stim_t;

  typedef struct {
    int          left;
    bit          stall;
    logic [31:0] tgt;
    int          fc;
    int          sc;
  } mst_t;

  typedef struct {
    bit          flush;
    bit          spc;
    bit          sif;
    bit          red;
    bit          busy;
    logic [31:0] tgt;
    int          fc;
    int          sc;
  } exp_t;

  logic        clk = 0;
  logic        rst;
  logic [4:0]  id_rs, id_rt, ex_rd;
  logic        id_uses_rs, id_uses_rt;
  logic        ex_readdmem, ex_branch_taken;
  logic [31:0] ex_target;

  logic        a_flush, a_spc, a_sif, a_red, a_busy;
  logic [31:0] a_tgt;
  logic [15:0] a_fc, a_sc;
  logic        b_flush, b_spc, b_sif, b_red, b_busy;
  logic [31:0] b_tgt;
  logic [1:0]  b_fc, b_sc;

  int vectors = 0;
  int miscompares = 0;
  exp_t qa[$];
  exp_t qb[$];
  mst_t sa, sb;

  always #5 clk = ~clk;

  hazard_flush_gen #(
    .REG_ADDR_W(5), .PC_W(32),
    .FLUSH_CYCLES(2), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_readdmem(ex_readdmem), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
    .flush(a_flush), .stall_pc(a_spc), .stall_ifid(a_sif),
    .pc_redirect(a_red), .pc_target(a_tgt), .busy(a_busy),
    .flush_events(a_fc), .stall_events(a_sc)
  );

  hazard_flush_gen #(
    .REG_ADDR_W(5), .PC_W(32),
    .FLUSH_CYCLES(3), .CNT_W(2)
  ) dut_b (
    .clk(clk), .rst(rst),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_readdmem(ex_readdmem), .ex_rd(ex_rd),
    .ex_branch_taken(ex_branch_taken), .ex_target(ex_target),
    .flush(b_flush), .stall_pc(b_spc), .stall_ifid(b_sif),
    .pc_redirect(b_red), .pc_target(b_tgt), .busy(b_busy),
    .flush_events(b_fc), .stall_events(b_sc)
  );

  // One cycle of the protocol: outputs for this cycle, state after the edge
  function automatic exp_t step(input mst_t s, input stim_t in,
                                input int fcyc, input int cmax,
                                output mst_t ns);
    exp_t e;
    bit hit;
    e = '{default: 0};
    e.fc = s.fc;
    e.sc = s.sc;
    e.tgt = s.tgt;
    ns = s;
    hit = in.ld && in.rd != 0 &&
          ((in.urs && in.rs == in.rd) || (in.urt && in.rt == in.rd));
    if (in.rst) begin
      e.tgt = 0;
      ns = '{left: 0, stall: 0, tgt: 0, fc: 0, sc: 0};
    end else if (s.left > 0) begin
      e.flush = 1;
      e.busy = 1;
      ns.left = s.left - 1;
    end else if (s.stall) begin
      e.busy = 1;
      ns.stall = 0;
    end else if (in.br) begin
      e.red = 1;
      e.flush = 1;
      e.tgt = in.tg;
      ns.tgt = in.tg;
      ns.left = fcyc - 1;
      if (s.fc < cmax) ns.fc = s.fc + 1;
    end else if (hit) begin
      e.flush = 1;
      e.spc = 1;
      e.sif = 1;
      ns.stall = 1;
      if (s.sc < cmax) ns.sc = s.sc + 1;
    end
    return e;
  endfunction

  task automatic apply(input stim_t s);
    mst_t n;
    @(posedge clk);
    #1;
    rst = s.rst;
    id_rs = s.rs;
    id_rt = s.rt;
    id_uses_rs = s.urs;
    id_uses_rt = s.urt;
    ex_readdmem = s.ld;
    ex_rd = s.rd;
    ex_branch_taken = s.br;
    ex_target = s.tg;
    qa.push_back(step(sa, s, 2, 65535, n));
    sa = n;
    qb.push_back(step(sb, s, 3, 3, n));
    sb = n;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h",
               name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk("a.flush", 64'(a_flush), 64'(e.flush));
      chk("a.stall_pc", 64'(a_spc), 64'(e.spc));
      chk("a.stall_ifid", 64'(a_sif), 64'(e.sif));
      chk("a.pc_redirect", 64'(a_red), 64'(e.red));
      chk("a.pc_target", 64'(a_tgt), 64'(e.tgt));
      chk("a.busy", 64'(a_busy), 64'(e.busy));
      chk("a.flush_events", 64'(a_fc), 64'(e.fc));
      chk("a.stall_events", 64'(a_sc), 64'(e.sc));
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk("b.flush", 64'(b_flush), 64'(e.flush));
      chk("b.stall_pc", 64'(b_spc), 64'(e.spc));
      chk("b.stall_ifid", 64'(b_sif), 64'(e.sif));
      chk("b.pc_redirect", 64'(b_red), 64'(e.red));
      chk("b.pc_target", 64'(b_tgt), 64'(e.tgt));
      chk("b.busy", 64'(b_busy), 64'(e.busy));
      chk("b.flush_events", 64'(b_fc), 64'(e.fc));
      chk("b.stall_events", 64'(b_sc), 64'(e.sc));
    end
  end

  initial begin
    stim_t s, idle_s;
    idle_s = '{default: 0};
    sa = '{left: 0, stall: 0, tgt: 0, fc: 0, sc: 0};
    sb = sa;
    rst = 1;
    id_rs = 0; id_rt = 0; ex_rd = 0;
    id_uses_rs = 0; id_uses_rt = 0;
    ex_readdmem = 0; ex_branch_taken = 1;
    ex_target = 32'h40;
    @(posedge clk);

    // reset held 3 cycles with a branch pending
    s = idle_s;
    s.rst = 1; s.br = 1; s.tg = 32'h40;
    repeat (3) apply(s);

    // single taken branch to 0x40
    s = idle_s;
    s.br = 1; s.tg = 32'h40;
    apply(s);
    repeat (4) apply(idle_s);

    // load-use on rs
    s = idle_s;
    s.ld = 1; s.rd = 5; s.rs = 5; s.urs = 1;
    apply(s);
    repeat (2) apply(idle_s);

    // no hazard: rd == 0, then rs unused
    s.rd = 0; s.rs = 0;
    apply(s);
    s.rd = 5; s.rs = 5; s.urs = 0;
    apply(s);
    // load-use on rt
    s.urt = 1; s.rt = 5;
    apply(s);
    repeat (2) apply(idle_s);

    // branch and load-use in the same cycle
    s = idle_s;
    s.ld = 1; s.rd = 7; s.rs = 7; s.urs = 1;
    s.br = 1; s.tg = 32'h1234;
    apply(s);
    repeat (4) apply(idle_s);

    // five back-to-back branches saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      s = idle_s;
      s.br = 1; s.tg = 32'h100 + 32'(i);
      repeat (3) apply(s);
    end
    apply(idle_s);

    // reset pulse in the middle of a flush
    s = idle_s;
    s.br = 1; s.tg = 32'h80;
    apply(s);
    s = idle_s;
    s.rst = 1;
    apply(s);
    repeat (3) apply(idle_s);

    for (int i = 0; i < 3000; i++) begin
      s.rst = ($urandom_range(0, 59) == 0);
      s.rs = 5'($urandom_range(0, 3));
      s.rt = 5'($urandom_range(0, 3));
      s.rd = 5'($urandom_range(0, 3));
      s.urs = 1'($urandom_range(0, 1));
      s.urt = 1'($urandom_range(0, 1));
      s.ld = 1'($urandom_range(0, 1));
      s.br = ($urandom_range(0, 3) == 0);
      s.tg = $urandom;
      apply(s);
    end
    apply(idle_s);

    for (int k = 0; k < 5; k++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(negedge clk);
    end
    if (qa.size() != 0 || qb.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expected entries never checked",
               qa.size(), qb.size());
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
